cmp_token_join: RTL and testbench

- Dataflow compare operator; successor of the single-mode equality node.
- Buffers tokens on each of two operand channels in small per-channel queues.
- Joins the queue heads and applies a runtime-selected comparison: EQ, NE, unsigned LT/GE, signed LT/GE.
- Emits a one-cycle result token. Sits between producer nodes and branch/select nodes in the dataflow fabric; tolerates operands arriving in different cycles.

---
 rtl/cmp_token_join_pkg.sv | 19 +
 rtl/cmp_token_join_fifo.sv | 67 ++++++
 rtl/cmp_token_join.sv | 82 ++++++++
 tb/tb_cmp_token_join.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_token_join_pkg.sv
// Shared definitions for the token-join compare node: compare-select encoding
// and the occupancy-count width helper.
package cmp_token_join_pkg;

  typedef enum logic [2:0] {
    OP_EQ  = 3'd0,
    OP_NE  = 3'd1,
    OP_LTU = 3'd2,
    OP_GEU = 3'd3,
    OP_LTS = 3'd4,
    OP_GES = 3'd5
  } cmp_op_e;

  // Counts must represent 0..DEPTH inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cmp_token_join_fifo.sv
// Per-channel token queue: circular buffer with registered occupancy.
// A push onto a full queue is accepted only when a pop frees a slot at the same edge.
module token_fifo
  import cmp_token_join_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [N-1:0]              din,
  output logic [N-1:0]              dout,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty,
  output logic                      drop
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [N-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cmp_token_join.sv
// Dataflow compare node: queues operand tokens per channel, joins the heads
// and emits a one-cycle result token carrying the selected comparison outcome.
module cmp_token_join
  import cmp_token_join_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic [2:0]             OP,
  input  logic                   R_IN1,
  input  logic [N-1:0]           D_IN1,
  input  logic                   R_IN2,
  input  logic [N-1:0]           D_IN2,
  output logic                   R_OUT,
  output logic [N-1:0]           D_OUT,
  output logic                   OVF,
  output logic [$clog2(DEPTH):0] CNT1,
  output logic [$clog2(DEPTH):0] CNT2
);

  logic [N-1:0] head_a, head_b;
  logic         empty_a, empty_b, full_a, full_b, drop_a, drop_b;
  logic         join_fire;
  logic         r_out_q, r_out_d;
  logic [N-1:0] d_out_q, d_out_d;
  logic         ovf_q, ovf_d;
  logic         unused_full;

  function automatic logic cmp_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic [2:0] op);
    case (op)
      OP_EQ:   return a == b;
      OP_NE:   return a != b;
      OP_LTU:  return a < b;
      OP_GEU:  return !(a < b);
      OP_LTS:  return $signed(a) < $signed(b);
      OP_GES:  return !($signed(a) < $signed(b));
      default: return 1'b0;
    endcase
  endfunction

  // Pairing uses registered occupancy only, so a fresh token waits one edge.
  assign join_fire   = EN && !empty_a && !empty_b;
  assign unused_full = &{1'b0, full_a, full_b};

  token_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_a (
    .clk(CLK), .rst(RST), .push(EN && R_IN1), .pop(join_fire), .din(D_IN1),
    .dout(head_a), .count(CNT1), .full(full_a), .empty(empty_a), .drop(drop_a)
  );

  token_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_b (
    .clk(CLK), .rst(RST), .push(EN && R_IN2), .pop(join_fire), .din(D_IN2),
    .dout(head_b), .count(CNT2), .full(full_b), .empty(empty_b), .drop(drop_b)
  );

  always_comb begin
    r_out_d = join_fire;
    d_out_d = d_out_q;
    ovf_d   = ovf_q | drop_a | drop_b;
    if (join_fire) d_out_d = {{(N-1){1'b0}}, cmp_fn(head_a, head_b, OP)};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_out_q <= 1'b0;
      d_out_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      r_out_q <= r_out_d;
      d_out_q <= d_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign R_OUT = r_out_q;
  assign D_OUT = d_out_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_cmp_token_join.sv
// Directed bench for cmp_token_join (N=16, DEPTH=4) with hand-computed expectations.
module tb_cmp_token_join;

  logic        CLK, RST, EN;
  logic [2:0]  OP;
  logic        R_IN1, R_IN2;
  logic [15:0] D_IN1, D_IN2;
  logic        R_OUT, OVF;
  logic [15:0] D_OUT;
  logic [2:0]  CNT1, CNT2;

  int n_assert = 0;
  int n_fail   = 0;

  cmp_token_join #(.N(16), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .OP(OP),
    .R_IN1(R_IN1), .D_IN1(D_IN1), .R_IN2(R_IN2), .D_IN2(D_IN2),
    .R_OUT(R_OUT), .D_OUT(D_OUT), .OVF(OVF), .CNT1(CNT1), .CNT2(CNT2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    R_IN1 = 1'b0;
    R_IN2 = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  logic [15:0] bvals [4];
  logic [15:0] ovf_exp [4];

  initial begin
    RST = 1'b1; EN = 1'b1; OP = 3'd0;
    R_IN1 = 1'b0; R_IN2 = 1'b0; D_IN1 = '0; D_IN2 = '0;
    tick(); tick();
    chk("rst_rout", R_OUT, 0);
    chk("rst_dout", D_OUT, 0);
    chk("rst_ovf",  OVF,   0);
    chk("rst_cnt1", CNT1,  0);
    chk("rst_cnt2", CNT2,  0);
    RST = 1'b0;

    // Same-cycle EQ pair
    OP = 3'd0; R_IN1 = 1; D_IN1 = 16'd5; R_IN2 = 1; D_IN2 = 16'd5;
    tick(); clear_in();
    chk("t1_cnt1_push", CNT1, 1);
    chk("t1_rout_early", R_OUT, 0);
    tick();
    chk("t1_rout", R_OUT, 1);
    chk("t1_dout", D_OUT, 1);
    chk("t1_cnt1", CNT1, 0);
    chk("t1_cnt2", CNT2, 0);
    tick();
    chk("t1_rout_pulse", R_OUT, 0);
    chk("t1_dout_hold", D_OUT, 1);

    // Skewed arrival, unsigned vs signed less-than
    OP = 3'd2; R_IN1 = 1; D_IN1 = 16'hFFFF;
    tick(); clear_in();
    chk("t2_c1_cnt1", CNT1, 1); chk("t2_c1_rout", R_OUT, 0);
    tick();
    chk("t2_c2_cnt1", CNT1, 1); chk("t2_c2_rout", R_OUT, 0);
    tick();
    chk("t2_c3_cnt1", CNT1, 1); chk("t2_c3_rout", R_OUT, 0);
    R_IN2 = 1; D_IN2 = 16'h0001;
    tick(); clear_in();
    chk("t2_b_cnt2", CNT2, 1); chk("t2_b_rout", R_OUT, 0);
    tick();
    chk("t2_ltu_rout", R_OUT, 1);
    chk("t2_ltu_dout", D_OUT, 0);
    chk("t2_ltu_cnt1", CNT1, 0);
    OP = 3'd4; R_IN1 = 1; D_IN1 = 16'hFFFF; R_IN2 = 1; D_IN2 = 16'h0001;
    tick(); clear_in(); tick();
    chk("t2_lts_rout", R_OUT, 1);
    chk("t2_lts_dout", D_OUT, 1);
    OP = 3'd6; R_IN1 = 1; D_IN1 = 16'd5; R_IN2 = 1; D_IN2 = 16'd5;
    tick(); clear_in(); tick();
    chk("t2_rsv_rout", R_OUT, 1);
    chk("t2_rsv_dout", D_OUT, 0);
    chk("t2_rsv_cnt1", CNT1, 0);

    // Overflow on queue A, then in-order pairing
    OP = 3'd0;
    for (int i = 0; i < 5; i++) begin
      R_IN1 = 1; D_IN1 = 16'((i + 1) * 10);
      tick();
      chk("ovf_cnt1", CNT1, (i < 4) ? i + 1 : 4);
      chk("ovf_flag", OVF, (i == 4) ? 1 : 0);
    end
    clear_in();
    bvals[0] = 16'd10; bvals[1] = 16'd20; bvals[2] = 16'd30; bvals[3] = 16'd99;
    ovf_exp[0] = 16'd1; ovf_exp[1] = 16'd1; ovf_exp[2] = 16'd1; ovf_exp[3] = 16'd0;
    for (int j = 0; j < 4; j++) begin
      R_IN2 = 1; D_IN2 = bvals[j];
      tick();
      chk("pair_cnt1", CNT1, 4 - j);
      chk("pair_cnt2", CNT2, 1);
      if (j == 0) chk("pair_rout0", R_OUT, 0);
      else begin
        chk("pair_rout", R_OUT, 1);
        chk("pair_dout", D_OUT, ovf_exp[j-1]);
      end
    end
    clear_in();
    tick();
    chk("pair_last_rout", R_OUT, 1);
    chk("pair_last_dout", D_OUT, ovf_exp[3]);
    chk("pair_last_cnt1", CNT1, 0);
    chk("pair_last_cnt2", CNT2, 0);
    chk("pair_ovf_sticky", OVF, 1);

    // Full queue with simultaneous push and pop
    do_reset();
    chk("rst2_ovf", OVF, 0);
    for (int i = 0; i < 4; i++) begin
      R_IN1 = 1; D_IN1 = 16'(i + 1);
      tick();
    end
    R_IN1 = 0; R_IN2 = 1; D_IN2 = 16'd1;
    tick();
    chk("full_cnt1", CNT1, 4);
    R_IN2 = 0; R_IN1 = 1; D_IN1 = 16'd7;
    tick(); clear_in();
    chk("full_pp_cnt1", CNT1, 4);
    chk("full_pp_ovf", OVF, 0);
    chk("full_pp_rout", R_OUT, 1);
    chk("full_pp_dout", D_OUT, 1);

    // Back-to-back streaming, GEU of i against 7-i
    do_reset();
    OP = 3'd3;
    for (int i = 0; i < 8; i++) begin
      R_IN1 = 1; D_IN1 = 16'(i); R_IN2 = 1; D_IN2 = 16'(7 - i);
      tick();
      chk("strm_cnt1", CNT1, 1);
      chk("strm_cnt2", CNT2, 1);
      if (i == 0) chk("strm_rout0", R_OUT, 0);
      else begin
        chk("strm_rout", R_OUT, 1);
        chk("strm_dout", D_OUT, (i - 1 >= 4) ? 1 : 0);
      end
    end
    clear_in();
    tick();
    chk("strm_last_rout", R_OUT, 1);
    chk("strm_last_dout", D_OUT, 1);
    chk("strm_last_cnt1", CNT1, 0);
    tick();
    chk("strm_idle_rout", R_OUT, 0);

    // Enable low freezes everything
    do_reset();
    OP = 3'd2; R_IN1 = 1; D_IN1 = 16'd3; R_IN2 = 1; D_IN2 = 16'd8;
    tick();
    EN = 0;
    for (int k = 0; k < 3; k++) begin
      R_IN1 = (k != 1); R_IN2 = (k != 0);
      D_IN1 = 16'($urandom); D_IN2 = 16'($urandom);
      tick();
      chk("en0_rout", R_OUT, 0);
      chk("en0_dout", D_OUT, 0);
      chk("en0_cnt1", CNT1, 1);
      chk("en0_cnt2", CNT2, 1);
      chk("en0_ovf", OVF, 0);
    end
    clear_in(); EN = 1;
    tick();
    chk("en1_rout", R_OUT, 1);
    chk("en1_dout", D_OUT, 1);
    chk("en1_cnt1", CNT1, 0);

    // Asynchronous reset mid-cycle
    OP = 3'd0;
    R_IN1 = 1; D_IN1 = 16'd50; tick();
    D_IN1 = 16'd51; tick();
    D_IN1 = 16'd52; R_IN2 = 1; D_IN2 = 16'd9; tick();
    R_IN2 = 0; D_IN1 = 16'd53; tick();
    clear_in();
    chk("arst_pre_cnt1", CNT1, 3);
    chk("arst_pre_rout", R_OUT, 1);
    #2 RST = 1;
    #1;
    chk("arst_rout", R_OUT, 0);
    chk("arst_dout", D_OUT, 0);
    chk("arst_ovf",  OVF,   0);
    chk("arst_cnt1", CNT1,  0);
    chk("arst_cnt2", CNT2,  0);
    #1 RST = 0;
    R_IN1 = 1; D_IN1 = 16'd9; R_IN2 = 1; D_IN2 = 16'd9;
    tick(); clear_in();
    chk("post_cnt1", CNT1, 1);
    chk("post_rout0", R_OUT, 0);
    tick();
    chk("post_rout", R_OUT, 1);
    chk("post_dout", D_OUT, 1);
    chk("post_cnt1_done", CNT1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
